// File: rtl/video_pkg.sv
// Shared video definitions for the camera capture path: frame geometry defaults,
// the RGB565 black pixel and the capture FSM state encoding.
package video_pkg;

  localparam int IMG_WIDTH_DEF  = 640;
  localparam int IMG_HEIGHT_DEF = 480;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_ARMED,
    ST_LINE,
    ST_GAP,
    ST_PAD_LINE,
    ST_PAD_FRAME,
    ST_DRAIN
  } cap_state_e;

endpackage

// File: rtl/cam_input_sync.sv
// Registers the camera bus once and derives vsync/href edges from the registered copies.
// One cycle of latency; no backpressure (the camera cannot be stalled).
module cam_input_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_data,
  output logic       vsync_r,
  output logic       href_r,
  output logic [7:0] data_r,
  output logic       vsync_rise,
  output logic       href_rise,
  output logic       href_fall
);

  logic       vsync_d, vsync_q;
  logic       href_d, href_q;
  logic [7:0] data_d, data_q;
  logic       vsync_p_d, vsync_p_q;
  logic       href_p_d, href_p_q;

  always_comb begin
    vsync_d   = cam_vsync;
    href_d    = cam_href;
    data_d    = cam_data;
    vsync_p_d = vsync_q;
    href_p_d  = href_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      data_q    <= 8'h00;
      vsync_p_q <= 1'b0;
      href_p_q  <= 1'b0;
    end else begin
      vsync_q   <= vsync_d;
      href_q    <= href_d;
      data_q    <= data_d;
      vsync_p_q <= vsync_p_d;
      href_p_q  <= href_p_d;
    end
  end

  assign vsync_r    = vsync_q;
  assign href_r     = href_q;
  assign data_r     = data_q;
  assign vsync_rise = vsync_q & ~vsync_p_q;
  assign href_rise  = href_q & ~href_p_q;
  assign href_fall  = ~href_q & href_p_q;

endmodule

// File: rtl/cam_pixel_capture.sv
// Assembles camera byte pairs into RGB565 pixels and forces exactly IMG_WIDTH x IMG_HEIGHT
// pixels per frame (pads with black, truncates extras); 2 clk from second byte to data_valid_out.
module cam_pixel_capture
  import video_pkg::*;
#(
  parameter int IMG_WIDTH   = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT  = IMG_HEIGHT_DEF,
  parameter int SKIP_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [15:0] pixel_out,
  output logic        data_valid_out,
  output logic        frame_start,
  output logic        frame_done,
  output logic        err_short_line,
  output logic        err_long_line,
  output logic        err_overrun,
  output logic [7:0]  frame_count
);

  localparam int XW  = $clog2(IMG_WIDTH + 1);
  localparam int YW  = $clog2(IMG_HEIGHT + 1);
  localparam int SKW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

  localparam logic [XW-1:0]  X_MAX    = XW'(IMG_WIDTH);
  localparam logic [XW-1:0]  X_LAST   = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0]  Y_LAST   = YW'(IMG_HEIGHT - 1);
  localparam logic [SKW-1:0] SKIP_TGT = SKW'(SKIP_FRAMES);

  logic       vsync_r, href_r, vsync_rise, href_rise, href_fall;
  logic [7:0] data_r;

  cam_input_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .vsync_r    (vsync_r),
    .href_r     (href_r),
    .data_r     (data_r),
    .vsync_rise (vsync_rise),
    .href_rise  (href_rise),
    .href_fall  (href_fall)
  );

  cap_state_e     state_d, state_q;
  logic [XW-1:0]  x_d, x_q;
  logic [YW-1:0]  y_d, y_q;
  logic           phase_d, phase_q;
  logic [SKW-1:0] skip_d, skip_q;
  logic [7:0]     hi_d, hi_q;
  logic [15:0]    pix_d, pix_q;
  logic           vld_d, vld_q;
  logic           fs_d, fs_q;
  logic           fd_d, fd_q;
  logic           short_d, short_q;
  logic           long_d, long_q;
  logic           ovr_d, ovr_q;
  logic [7:0]     fcnt_d, fcnt_q;
  logic           emit;
  logic [15:0]    emit_pix;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    phase_d  = phase_q;
    skip_d   = skip_q;
    hi_d     = hi_q;
    pix_d    = RGB565_BLACK;
    vld_d    = 1'b0;
    fs_d     = 1'b0;
    fd_d     = 1'b0;
    short_d  = short_q;
    long_d   = long_q;
    ovr_d    = ovr_q;
    fcnt_d   = fcnt_q;
    emit     = 1'b0;
    emit_pix = RGB565_BLACK;

    unique case (state_q)
      ST_SYNC: begin
        if (vsync_rise) begin
          if (skip_q == SKIP_TGT) state_d = ST_ARMED;
          else                    skip_d  = skip_q + 1'b1;
        end
      end

      // The href-high cycle that ends ARMED already carries the first byte of the line.
      ST_ARMED: begin
        if (!vsync_r && href_r) begin
          state_d = ST_LINE;
          x_d     = '0;
          y_d     = '0;
          phase_d = 1'b1;
          hi_d    = data_r;
        end
      end

      ST_LINE: begin
        if (href_r) begin
          if (!phase_q) begin
            hi_d    = data_r;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (x_q < X_MAX) begin
              emit     = 1'b1;
              emit_pix = {hi_q, data_r};
              x_d      = x_q + 1'b1;
            end else begin
              long_d = 1'b1;
            end
          end
        end else if (href_fall) begin
          phase_d = 1'b0;
          if (x_q < X_MAX) begin
            short_d = 1'b1;
            state_d = ST_PAD_LINE;
          end else begin
            y_d     = y_q + 1'b1;
            state_d = (y_q == Y_LAST) ? ST_DRAIN : ST_GAP;
          end
        end
      end

      ST_PAD_LINE: begin
        if (href_r) ovr_d = 1'b1;
        emit = 1'b1;
        x_d  = x_q + 1'b1;
        if (x_q == X_LAST) begin
          y_d = y_q + 1'b1;
          if (y_q == Y_LAST) begin
            state_d = vsync_rise ? ST_ARMED : ST_DRAIN;
          end else if (vsync_r) begin
            // vsync arrived while padding: the GAP edge would be missed, so pad the frame now.
            short_d = 1'b1;
            x_d     = '0;
            state_d = ST_PAD_FRAME;
          end else begin
            state_d = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        if (href_rise) begin
          state_d = ST_LINE;
          x_d     = '0;
          phase_d = 1'b1;
          hi_d    = data_r;
        end else if (vsync_rise) begin
          short_d = 1'b1;
          x_d     = '0;
          state_d = ST_PAD_FRAME;
        end
      end

      ST_PAD_FRAME: begin
        if (href_r) ovr_d = 1'b1;
        emit = 1'b1;
        if (x_q == X_LAST) begin
          x_d = '0;
          y_d = y_q + 1'b1;
          if (y_q == Y_LAST) state_d = ST_ARMED;
        end else begin
          x_d = x_q + 1'b1;
        end
      end

      ST_DRAIN: begin
        if (href_r)     long_d  = 1'b1;
        if (vsync_rise) state_d = ST_ARMED;
      end

      default: state_d = ST_SYNC;
    endcase

    if (emit) begin
      vld_d = 1'b1;
      pix_d = emit_pix;
      fs_d  = (x_q == '0) && (y_q == '0);
      fd_d  = (x_q == X_LAST) && (y_q == Y_LAST);
      if (fd_d) fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SYNC;
      x_q     <= '0;
      y_q     <= '0;
      phase_q <= 1'b0;
      skip_q  <= '0;
      hi_q    <= 8'h00;
      pix_q   <= RGB565_BLACK;
      vld_q   <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      ovr_q   <= 1'b0;
      fcnt_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      phase_q <= phase_d;
      skip_q  <= skip_d;
      hi_q    <= hi_d;
      pix_q   <= pix_d;
      vld_q   <= vld_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
      short_q <= short_d;
      long_q  <= long_d;
      ovr_q   <= ovr_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign pixel_out      = pix_q;
  assign data_valid_out = vld_q;
  assign frame_start    = fs_q;
  assign frame_done     = fd_q;
  assign err_short_line = short_q;
  assign err_long_line  = long_q;
  assign err_overrun    = ovr_q;
  assign frame_count    = fcnt_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Bench for cam_pixel_capture with a 4x3 frame and one skipped frame; random camera
// traffic is compared against a per-frame model of the delivered pixel grid.
module tb_cam_pixel_capture;

  localparam int W = 4;
  localparam int H = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic [15:0] pixel_out;
  logic        data_valid_out, frame_start, frame_done;
  logic        err_short_line, err_long_line, err_overrun;
  logic [7:0]  frame_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stray = 0;
  int t_first = 0;

  logic [7:0]  lb [8][16];
  int          ll [8];
  int          nl;

  logic [15:0] exp_pix[$], got_pix[$];
  bit          exp_fs[$], exp_fd[$], got_fs[$], got_fd[$];
  int          got_cyc[$];
  bit          exp_short, exp_long, exp_ovr;
  logic [7:0]  exp_fc;

  cam_pixel_capture #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .SKIP_FRAMES(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cam_vsync      (cam_vsync),
    .cam_href       (cam_href),
    .cam_data       (cam_data),
    .pixel_out      (pixel_out),
    .data_valid_out (data_valid_out),
    .frame_start    (frame_start),
    .frame_done     (frame_done),
    .err_short_line (err_short_line),
    .err_long_line  (err_long_line),
    .err_overrun    (err_overrun),
    .frame_count    (frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid_out) begin
      got_pix.push_back(pixel_out);
      got_fs.push_back(frame_start);
      got_fd.push_back(frame_done);
      got_cyc.push_back(cyc);
    end else if (frame_start || frame_done) begin
      stray++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    exp_pix.delete(); exp_fs.delete(); exp_fd.delete();
    got_pix.delete(); got_fs.delete(); got_fd.delete(); got_cyc.delete();
  endtask

  // len < 0 picks a random length per line
  task automatic rand_frame(input int n, input int len);
    nl = n;
    for (int l = 0; l < 8; l++) begin
      ll[l] = (len < 0) ? int'($urandom_range(1, 11)) : len;
      for (int b = 0; b < 16; b++) lb[l][b] = 8'($urandom);
    end
  endtask

  task automatic send_frame(input int ovr);
    cam_vsync = 1'b1; repeat (16) tick();
    cam_vsync = 1'b0; repeat (3) tick();
    for (int l = 0; l < nl; l++) begin
      cam_href = 1'b1;
      for (int b = 0; b < ll[l]; b++) begin
        cam_data = lb[l][b];
        if (l == 0 && b == 1) t_first = cyc;
        tick();
      end
      cam_href = 1'b0; cam_data = 8'($urandom); tick();
      if (l == ovr) begin
        cam_href = 1'b1;
        repeat (2) begin cam_data = 8'($urandom); tick(); end
        cam_href = 1'b0;
      end
      repeat (8) tick();
    end
  endtask

  task automatic flush();
    cam_vsync = 1'b1; repeat (16) tick();
    cam_vsync = 1'b0; repeat (3) tick();
  endtask

  // Delivered grid: real pairs where the line supplied them, black everywhere else.
  task automatic model_frame();
    logic [15:0] p;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        p = 16'h0000;
        if (y < nl && x < ll[y] / 2) p = {lb[y][2*x], lb[y][2*x+1]};
        exp_pix.push_back(p);
        exp_fs.push_back(x == 0 && y == 0);
        exp_fd.push_back(x == W - 1 && y == H - 1);
      end
    end
    for (int y = 0; y < nl; y++) begin
      if (y < H && ll[y] / 2 < W) exp_short = 1'b1;
      if (y >= H || ll[y] / 2 > W) exp_long = 1'b1;
    end
    if (nl < H) exp_short = 1'b1;
    exp_fc = exp_fc + 8'd1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    exp_short = 0; exp_long = 0; exp_ovr = 0; exp_fc = 8'd0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({pixel_out, data_valid_out, frame_start, frame_done} !== 19'd0) begin
      bad++; $display("FAIL reset_datapath got=%h/%b/%b/%b want all zero", pixel_out, data_valid_out, frame_start, frame_done);
    end
    total++;
    if ({err_short_line, err_long_line, err_overrun, frame_count} !== 11'd0) begin
      bad++; $display("FAIL reset_status got=%b%b%b fc=%0d want zero", err_short_line, err_long_line, err_overrun, frame_count);
    end
  endtask

  task automatic test_basic();
    clear_q();
    rand_frame(3, 8);
    send_frame(-1);
    total++;
    if (got_pix.size() != 0) begin bad++; $display("FAIL skip_frame got=%0d valids want 0", got_pix.size()); end
    for (int l = 0; l < 3; l++) for (int b = 0; b < 8; b++) lb[l][b] = 8'(l * 8 + b + 1);
    clear_q();
    send_frame(-1);
    model_frame();
    total++;
    if (got_pix.size() != exp_pix.size()) begin
      bad++; $display("FAIL basic_count got=%0d want=%0d", got_pix.size(), exp_pix.size());
    end else for (int i = 0; i < exp_pix.size(); i++) begin
      total++;
      if ({got_pix[i], got_fs[i], got_fd[i]} !== {exp_pix[i], exp_fs[i], exp_fd[i]}) begin
        bad++; $display("FAIL basic_pix[%0d] got=%h/%b/%b want=%h/%b/%b", i, got_pix[i], got_fs[i], got_fd[i], exp_pix[i], exp_fs[i], exp_fd[i]);
      end
    end
    total++;
    if (got_pix.size() != 12 || got_pix[0] !== 16'h0102 || got_pix[11] !== 16'h1718) begin
      bad++; $display("FAIL basic_ends got n=%0d first=%h last=%h want 12/0102/1718", got_pix.size(), got_pix[0], got_pix[got_pix.size()-1]);
    end
    total++;
    if (got_cyc.size() == 0 || got_cyc[0] != t_first + 2) begin
      bad++; $display("FAIL basic_latency got=%0d want=%0d", (got_cyc.size() == 0) ? -1 : got_cyc[0] - t_first, 2);
    end
    total++;
    if ({err_short_line, err_long_line, err_overrun, frame_count} !== {exp_short, exp_long, exp_ovr, exp_fc}) begin
      bad++; $display("FAIL basic_status got=%b%b%b fc=%0d want=%b%b%b fc=%0d", err_short_line, err_long_line, err_overrun, frame_count, exp_short, exp_long, exp_ovr, exp_fc);
    end
    flush();
  endtask

  task automatic test_short_line();
    clear_q();
    rand_frame(3, 8);
    ll[1] = 4;
    send_frame(-1);
    model_frame();
    flush();
    total++;
    if (got_pix.size() != exp_pix.size()) begin
      bad++; $display("FAIL short_count got=%0d want=%0d", got_pix.size(), exp_pix.size());
    end else for (int i = 0; i < exp_pix.size(); i++) begin
      total++;
      if ({got_pix[i], got_fs[i], got_fd[i]} !== {exp_pix[i], exp_fs[i], exp_fd[i]}) begin
        bad++; $display("FAIL short_pix[%0d] got=%h/%b/%b want=%h/%b/%b", i, got_pix[i], got_fs[i], got_fd[i], exp_pix[i], exp_fs[i], exp_fd[i]);
      end
    end
    total++;
    if (got_cyc.size() < 8 || got_cyc[7] != got_cyc[6] + 1) begin
      bad++; $display("FAIL short_pad_spacing got n=%0d want consecutive pad cycles", got_cyc.size());
    end
    total++;
    if ({err_short_line, err_long_line, err_overrun, frame_count} !== {1'b1, exp_long, exp_ovr, exp_fc}) begin
      bad++; $display("FAIL short_status got=%b%b%b fc=%0d want=1%b%b fc=%0d", err_short_line, err_long_line, err_overrun, frame_count, exp_long, exp_ovr, exp_fc);
    end
  endtask

  task automatic test_long_line();
    clear_q();
    rand_frame(3, 8);
    ll[2] = 10;
    send_frame(-1);
    model_frame();
    flush();
    total++;
    if (got_pix.size() != exp_pix.size()) begin
      bad++; $display("FAIL long_count got=%0d want=%0d", got_pix.size(), exp_pix.size());
    end else for (int i = 0; i < exp_pix.size(); i++) begin
      total++;
      if ({got_pix[i], got_fs[i], got_fd[i]} !== {exp_pix[i], exp_fs[i], exp_fd[i]}) begin
        bad++; $display("FAIL long_pix[%0d] got=%h/%b/%b want=%h/%b/%b", i, got_pix[i], got_fs[i], got_fd[i], exp_pix[i], exp_fs[i], exp_fd[i]);
      end
    end
    total++;
    if ({err_short_line, err_long_line, err_overrun, frame_count} !== {exp_short, 1'b1, exp_ovr, exp_fc}) begin
      bad++; $display("FAIL long_status got=%b%b%b fc=%0d want=%b1%b fc=%0d", err_short_line, err_long_line, err_overrun, frame_count, exp_short, exp_ovr, exp_fc);
    end
  endtask

  task automatic test_early_vsync();
    clear_q();
    rand_frame(1, 8);
    send_frame(-1);
    model_frame();
    rand_frame(3, 8);
    send_frame(-1);
    model_frame();
    flush();
    total++;
    if (got_pix.size() != exp_pix.size()) begin
      bad++; $display("FAIL early_count got=%0d want=%0d", got_pix.size(), exp_pix.size());
    end else for (int i = 0; i < exp_pix.size(); i++) begin
      total++;
      if ({got_pix[i], got_fs[i], got_fd[i]} !== {exp_pix[i], exp_fs[i], exp_fd[i]}) begin
        bad++; $display("FAIL early_pix[%0d] got=%h/%b/%b want=%h/%b/%b", i, got_pix[i], got_fs[i], got_fd[i], exp_pix[i], exp_fs[i], exp_fd[i]);
      end
    end
    total++;
    if ({err_short_line, err_long_line, err_overrun, frame_count} !== {exp_short, exp_long, exp_ovr, exp_fc}) begin
      bad++; $display("FAIL early_status got=%b%b%b fc=%0d want=%b%b%b fc=%0d", err_short_line, err_long_line, err_overrun, frame_count, exp_short, exp_long, exp_ovr, exp_fc);
    end
  endtask

  task automatic test_overrun();
    clear_q();
    rand_frame(3, 8);
    ll[0] = 2;
    send_frame(0);
    model_frame();
    exp_ovr = 1'b1;
    flush();
    total++;
    if (got_pix.size() != exp_pix.size()) begin
      bad++; $display("FAIL ovr_count got=%0d want=%0d", got_pix.size(), exp_pix.size());
    end else for (int i = 0; i < exp_pix.size(); i++) begin
      total++;
      if ({got_pix[i], got_fs[i], got_fd[i]} !== {exp_pix[i], exp_fs[i], exp_fd[i]}) begin
        bad++; $display("FAIL ovr_pix[%0d] got=%h/%b/%b want=%h/%b/%b", i, got_pix[i], got_fs[i], got_fd[i], exp_pix[i], exp_fs[i], exp_fd[i]);
      end
    end
    total++;
    if ({err_short_line, err_long_line, err_overrun, frame_count} !== {exp_short, exp_long, exp_ovr, exp_fc}) begin
      bad++; $display("FAIL ovr_status got=%b%b%b fc=%0d want=%b%b%b fc=%0d", err_short_line, err_long_line, err_overrun, frame_count, exp_short, exp_long, exp_ovr, exp_fc);
    end
  endtask

  task automatic test_random();
    clear_q();
    for (int f = 0; f < 6; f++) begin
      rand_frame(int'($urandom_range(1, 4)), -1);
      send_frame(-1);
      model_frame();
    end
    flush();
    total++;
    if (got_pix.size() != exp_pix.size()) begin
      bad++; $display("FAIL rand_count got=%0d want=%0d", got_pix.size(), exp_pix.size());
    end else for (int i = 0; i < exp_pix.size(); i++) begin
      total++;
      if ({got_pix[i], got_fs[i], got_fd[i]} !== {exp_pix[i], exp_fs[i], exp_fd[i]}) begin
        bad++; $display("FAIL rand_pix[%0d] got=%h/%b/%b want=%h/%b/%b", i, got_pix[i], got_fs[i], got_fd[i], exp_pix[i], exp_fs[i], exp_fd[i]);
      end
    end
    total++;
    if ({err_short_line, err_long_line, err_overrun, frame_count} !== {exp_short, exp_long, exp_ovr, exp_fc}) begin
      bad++; $display("FAIL rand_status got=%b%b%b fc=%0d want=%b%b%b fc=%0d", err_short_line, err_long_line, err_overrun, frame_count, exp_short, exp_long, exp_ovr, exp_fc);
    end
    total++;
    if (stray != 0) begin bad++; $display("FAIL stray_pulses got=%0d want=0", stray); end
  endtask

  task automatic test_midreset();
    rand_frame(3, 8);
    cam_vsync = 1'b1; repeat (16) tick();
    cam_vsync = 1'b0; repeat (3) tick();
    cam_href = 1'b1;
    for (int b = 0; b < 8; b++) begin cam_data = lb[0][b]; tick(); end
    cam_href = 1'b0; repeat (8) tick();
    cam_href = 1'b1;
    for (int b = 0; b < 3; b++) begin cam_data = lb[1][b]; tick(); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({pixel_out, data_valid_out, frame_start, frame_done, err_short_line, err_long_line, err_overrun, frame_count} !== 30'd0) begin
      bad++; $display("FAIL midreset_outputs got=%h/%b/%b/%b/%b%b%b fc=%0d want all zero", pixel_out, data_valid_out, frame_start, frame_done, err_short_line, err_long_line, err_overrun, frame_count);
    end
    cam_href = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    exp_short = 0; exp_long = 0; exp_ovr = 0; exp_fc = 8'd0;
    clear_q();
    rand_frame(3, 8);
    send_frame(-1);
    total++;
    if (got_pix.size() != 0) begin bad++; $display("FAIL midreset_skip got=%0d valids want 0", got_pix.size()); end
    rand_frame(3, -1);
    send_frame(-1);
    model_frame();
    flush();
    total++;
    if (got_pix.size() != exp_pix.size()) begin
      bad++; $display("FAIL midreset_count got=%0d want=%0d", got_pix.size(), exp_pix.size());
    end else for (int i = 0; i < exp_pix.size(); i++) begin
      total++;
      if ({got_pix[i], got_fs[i], got_fd[i]} !== {exp_pix[i], exp_fs[i], exp_fd[i]}) begin
        bad++; $display("FAIL midreset_pix[%0d] got=%h/%b/%b want=%h/%b/%b", i, got_pix[i], got_fs[i], got_fd[i], exp_pix[i], exp_fs[i], exp_fd[i]);
      end
    end
    total++;
    if ({err_short_line, err_long_line, err_overrun, frame_count} !== {exp_short, exp_long, exp_ovr, exp_fc}) begin
      bad++; $display("FAIL midreset_status got=%b%b%b fc=%0d want=%b%b%b fc=%0d", err_short_line, err_long_line, err_overrun, frame_count, exp_short, exp_long, exp_ovr, exp_fc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_line();
    test_long_line();
    test_early_vsync();
    test_overrun();
    test_random();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_pixel_capture.md
Name: cam_pixel_capture

Overview:
- Upstream feeder of the face detection stage.
- Receives the 8-bit camera bus (VSYNC/HREF/D[7:0]) and assembles byte pairs into RGB565 pixels.
- Guarantees exactly IMG_WIDTH x IMG_HEIGHT qualified pixels per frame: pads short lines/frames with black, truncates long lines, drops extra lines.
- Skips the first SKIP_FRAMES frames after reset while the sensor settles.

Parameters:
- IMG_WIDTH, 640, pixels per line delivered downstream
- IMG_HEIGHT, 480, lines per frame delivered downstream
- SKIP_FRAMES, 2, complete frames discarded after reset (0 = none)

Ports:
- clk  input  1  camera pixel clock; the only clock
- rst_n  input  1  asynchronous active-low reset
- cam_vsync  input  1  frame sync, high during vertical blanking
- cam_href  input  1  line valid, high while bytes are valid
- cam_data  input  8  camera byte
- pixel_out  output  16  RGB565 pixel to detection stage
- data_valid_out  output  1  pixel_out qualifier, one pixel per cycle max
- frame_start  output  1  pulse with pixel (0,0)
- frame_done  output  1  pulse with pixel (IMG_WIDTH-1, IMG_HEIGHT-1)
- err_short_line  output  1  sticky: a line was padded
- err_long_line  output  1  sticky: bytes truncated or extra lines dropped
- err_overrun  output  1  sticky: camera bytes arrived during padding
- frame_count  output  8  delivered frames, wraps 255->0

Behaviour:
- Reset (async, rst_n low): all outputs 0; state SYNC; x, y, byte phase, skip counter cleared. Mid-frame reset abandons the frame; skipping restarts.
- Input stage: cam_vsync/cam_href/cam_data registered once. All decisions use registered copies. The vsync rising edge is detected on the registered signal.
- Assembly: the first byte of a pair is pixel[15:8], the second is pixel[7:0]. data_valid_out is high the cycle after the second byte is registered, so latency = 2 clk from the second byte at the pins.
- States:
  - SYNC: on vsync rise, if skip_cnt == SKIP_FRAMES go ARMED, else skip_cnt++.
  - ARMED: wait for vsync low and href high. Enter LINE with x=0, y=0, phase=0.
  - LINE:
    - Each href-high cycle toggles phase; phase 1 emits a pixel if x < IMG_WIDTH, else sets err_long_line and discards. x increments per completed pair.
    - href fall with a trailing odd byte: byte discarded, phase=0.
    - href fall with x < IMG_WIDTH: set err_short_line, go PAD_LINE.
    - href fall otherwise: y++, go GAP, or DRAIN if y reaches IMG_HEIGHT.
  - PAD_LINE: emit 16'h0000 once per cycle until x == IMG_WIDTH. Then y++ and go GAP or DRAIN. href high while padding sets err_overrun; those bytes are discarded.
  - GAP:
    - href rise goes to LINE (x=0, phase=0).
    - vsync rise with y < IMG_HEIGHT sets err_short_line and goes PAD_FRAME.
  - PAD_FRAME: emit zeros once per cycle through remaining lines until (IMG_WIDTH-1, IMG_HEIGHT-1) is emitted, then go ARMED. Camera bytes here set err_overrun and are discarded.
  - DRAIN: frame complete. Any href-high cycle sets err_long_line. vsync rise goes ARMED.
- frame_start/frame_done are single-cycle and coincide with the qualifying data_valid_out, for real and padded pixels alike.
- frame_count increments on the frame_done cycle.
- Simultaneous padding completion and vsync rise: the frame completes; the vsync edge is consumed (go ARMED).
- x/y widths: $clog2 of IMG_WIDTH+1 and IMG_HEIGHT+1. No wrap inside a frame.
- Error flags clear only on reset.

Decomposition:
- Shared package (video_pkg):
  - IMG_WIDTH/IMG_HEIGHT defaults
  - RGB565 black constant
  - state enum encoding (SYNC, ARMED, LINE, GAP, PAD_LINE, PAD_FRAME, DRAIN)
- One natural sub-module: cam_input_sync, the input register stage plus vsync/href edge detection. The FSM, counters and assembly stay in the top.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=3, SKIP_FRAMES=1):
- Reset, one full frame, then a second frame of 3 lines x 8 bytes (0x01..0x18) -> first frame produces no valid. Second frame: 12 valids, first pixel 16'h0102, last 16'h1718, frame_start/frame_done on those cycles, frame_count=1.
- Line 2 carries only 4 bytes -> pixels 2-3 of that line are 16'h0000 emitted in consecutive cycles after href fall; err_short_line=1; still 12 valids.
- Line with 10 bytes -> 4 pixels delivered; err_long_line=1; the 5th pixel is not emitted.
- vsync rises after 1 line -> 8 padded zero pixels; frame_done on the last; next frame captured normally.
- href reasserted 1 cycle after a 2-byte line ends -> err_overrun=1; pixel count per frame remains 12.
- rst_n pulsed low mid-line 2 -> all outputs 0 immediately; next captured frame delivered only after one skipped frame.
